// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner with a double-buffered digit bank.
// Optional per-digit blanking input is enabled by defining SEG_SCAN_BLANK_EN.
module seg_scan #(
  parameter int DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       upd,
`ifdef SEG_SCAN_BLANK_EN
  input  logic [3:0] blank,
`endif
  output logic [3:0] data,
  output logic [3:0] dig,
  output logic       pend,
  output logic       frame
);

  localparam logic [15:0] CntMax = 16'(DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  dig_q, dig_d;
  logic [3:0]  data_q, data_d;
  logic [3:0]  shadow_q [4];
  logic [3:0]  shadow_d [4];
  logic [3:0]  active_q [4];
  logic [3:0]  active_d [4];
  logic        pend_q, pend_d;
  logic        frame_q, frame_d;
  logic        tick, wrap, commit;

  always_comb begin
    tick     = (cnt_q == CntMax);
    wrap     = tick && (idx_q == 2'd3);
    commit   = wrap && pend_q;
    cnt_d    = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    dig_d    = 4'b0001 << idx_d;
    shadow_d = shadow_q;
    if (wr_en) shadow_d[wr_addr] = wr_data;
    // Commit copies the shadow next-state so a write in the wrap cycle is included.
    active_d = commit ? shadow_d : active_q;
    pend_d   = commit ? upd : (pend_q | upd);
    frame_d  = wrap;
    // Output digit code is registered from next-state so the new slot shows at once.
    data_d   = active_d[idx_d];
`ifdef SEG_SCAN_BLANK_EN
    if (blank[idx_d]) data_d = 4'hF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 16'd0;
      idx_q   <= 2'd0;
      dig_q   <= 4'b0001;
      data_q  <= 4'hF;
      pend_q  <= 1'b0;
      frame_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= 4'hF;
        active_q[i] <= 4'hF;
      end
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dig_q    <= dig_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign data  = data_q;
  assign dig   = dig_q;
  assign pend  = pend_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: table vectors, directed corner sequences and random traffic
// checked against a cycle-count based reference model (DIV=4), plus a DIV=1 scan check.
module tb_seg_scan;
  localparam int DIV = 4;
  localparam int FR  = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'd0;
  logic       upd = 1'b0;
  logic [3:0] data, dig, data1, dig1;
  logic       pend, frame, pend1, frame1;
`ifdef SEG_SCAN_BLANK_EN
  logic [3:0] blank0 = 4'b0000;
  logic [3:0] blank1 = 4'b0101;
`endif

  seg_scan #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .upd(upd),
`ifdef SEG_SCAN_BLANK_EN
    .blank(blank0),
`endif
    .data(data), .dig(dig), .pend(pend), .frame(frame)
  );

  seg_scan #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .upd(upd),
`ifdef SEG_SCAN_BLANK_EN
    .blank(blank1),
`endif
    .data(data1), .dig(dig1), .pend(pend1), .frame(frame1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: edges since reset release, both banks, request flag.
  int         m_cyc;
  logic [3:0] m_sh [4];
  logic [3:0] m_ac [4];
  logic       m_pend, m_frame;

  typedef struct {
    logic       we;
    logic [1:0] a;
    logic [3:0] d;
    logic       u;
    logic [3:0] e_data;
    logic [3:0] e_dig;
    logic       e_pend;
    logic       e_frame;
  } vec_t;
  vec_t tv [17];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_cyc = 0;
    m_pend = 1'b0;
    m_frame = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = 4'hF;
      m_ac[i] = 4'hF;
    end
  endfunction

  task automatic step();
    int  idx;
    logic wrp;
    @(posedge clk);
    wrp = ((m_cyc % DIV) == DIV - 1) && (((m_cyc / DIV) % 4) == 3);
    if (wr_en) m_sh[wr_addr] = wr_data;
    if (wrp && m_pend) begin
      for (int i = 0; i < 4; i++) m_ac[i] = m_sh[i];
      m_pend = upd;
    end else begin
      m_pend = m_pend | upd;
    end
    m_frame = wrp;
    m_cyc++;
    #1;
    idx = (m_cyc / DIV) % 4;
    chk("model_dig",   32'(dig),   32'(1) << idx);
    chk("model_data",  32'(data),  32'(m_ac[idx]));
    chk("model_pend",  32'(pend),  32'(m_pend));
    chk("model_frame", 32'(frame), 32'(m_frame));
  endtask

  task automatic drive(input logic we, input logic [1:0] a, input logic [3:0] d, input logic u);
    wr_en = we; wr_addr = a; wr_data = d; upd = u;
    step();
    wr_en = 1'b0; upd = 1'b0;
  endtask

  task automatic advance_to(input int ph);
    int n = 0;
    while ((m_cyc % FR) != ph && n < 2 * FR) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dig",   32'(dig),   32'h1);
    chk("rst_data",  32'(data),  32'hF);
    chk("rst_pend",  32'(pend),  32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [3:0] exp;
    tv[0]  = '{1'b1, 2'd0, 4'd1, 1'b0, 4'hF, 4'b0001, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 2'd1, 4'd2, 1'b0, 4'hF, 4'b0001, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 2'd2, 4'd3, 1'b0, 4'hF, 4'b0001, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 2'd3, 4'd4, 1'b0, 4'hF, 4'b0010, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0010, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0010, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0010, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0100, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0100, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0100, 1'b0, 1'b0};
    tv[10] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0100, 1'b0, 1'b0};
    tv[11] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b1000, 1'b0, 1'b0};
    tv[12] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b1000, 1'b0, 1'b0};
    tv[13] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b1000, 1'b0, 1'b0};
    tv[14] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b1000, 1'b0, 1'b0};
    tv[15] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0001, 1'b0, 1'b1};
    tv[16] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'hF, 4'b0001, 1'b0, 1'b0};

    #2;
    do_reset();

    // Writes without commit: active bank stays blank across frames.
    for (int i = 0; i < 17; i++) begin
      drive(tv[i].we, tv[i].a, tv[i].d, tv[i].u);
      chk($sformatf("tv%0d_data", i),  32'(data),  32'(tv[i].e_data));
      chk($sformatf("tv%0d_dig", i),   32'(dig),   32'(tv[i].e_dig));
      chk($sformatf("tv%0d_pend", i),  32'(pend),  32'(tv[i].e_pend));
      chk($sformatf("tv%0d_frame", i), 32'(frame), 32'(tv[i].e_frame));
    end
    repeat (2 * FR) step();
    chk("nocommit_data", 32'(data), 32'hF);

    // Mid-frame commit request waits for the wrap.
    drive(1'b0, 2'd0, 4'd0, 1'b1);
    chk("upd_pend", 32'(pend), 32'h1);
    n = 0;
    while (frame !== 1'b1 && n < 2 * FR) begin
      step();
      n++;
    end
    chk("commit_frame", 32'(frame), 32'h1);
    chk("commit_pend",  32'(pend),  32'h0);
    chk("slot0_data",   32'(data),  32'h1);
    chk("slot0_dig",    32'(dig),   32'h1);
    for (int s = 1; s < 4; s++) begin
      repeat (DIV) step();
      chk($sformatf("slot%0d_data", s), 32'(data), 32'(s + 1));
      chk($sformatf("slot%0d_dig", s),  32'(dig),  32'(1) << s);
    end

    // Write landing in the commit cycle is part of the committed copy.
    drive(1'b0, 2'd0, 4'd0, 1'b1);
    advance_to(FR - 1);
    drive(1'b1, 2'd0, 4'd5, 1'b0);
    chk("wrapwr_data", 32'(data), 32'h5);
    chk("wrapwr_dig",  32'(dig),  32'h1);
    chk("wrapwr_pend", 32'(pend), 32'h0);

    // Request coincident with a commit re-arms for the following wrap.
    drive(1'b0, 2'd0, 4'd0, 1'b1);
    advance_to(FR - 1);
    drive(1'b0, 2'd0, 4'd0, 1'b1);
    chk("rearm_pend",  32'(pend),  32'h1);
    chk("rearm_frame", 32'(frame), 32'h1);
    advance_to(FR - 1);
    step();
    chk("rearm_clear", 32'(pend), 32'h0);

    // Reset at idx=2 with a pending commit discards it and the shadow bank.
    drive(1'b1, 2'd1, 4'd9, 1'b1);
    advance_to(2 * DIV + 1);
    chk("prerst_pend", 32'(pend), 32'h1);
    do_reset();
    advance_to(FR - 1);
    step();
    chk("postrst_frame", 32'(frame), 32'h1);
    chk("postrst_pend",  32'(pend),  32'h0);
    chk("postrst_data",  32'(data),  32'hF);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 15) == 0));
    end

    // DIV=1 instance: one slot per cycle, four-cycle frames.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 4'(i + 1), 1'b0);
    drive(1'b0, 2'd0, 4'd0, 1'b1);
    n = 0;
    while (pend1 === 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk("div1_frame", 32'(frame1), 32'h1);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = k % 4;
`ifdef SEG_SCAN_BLANK_EN
      exp = blank1[i] ? 4'hF : 4'(i + 1);
`else
      exp = 4'(i + 1);
`endif
      chk($sformatf("div1_dig%0d", k),  32'(dig1),  32'(1) << i);
      chk($sformatf("div1_data%0d", k), 32'(data1), 32'(exp));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
